// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine with busy/done handshake, zero-operand shortcut and
// per-operation compute-edge count.
module gcd_stein #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(4*WIDTH+5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StStrip, StOddx, StLoop, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, r_q, r_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             busy_st;

  assign busy_st = (state_q == StStrip) || (state_q == StOddx) || (state_q == StLoop);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    r_d      = r_q;
    cycles_d = cycles_q;
    done_d   = done_q;
    cnt_d    = busy_st ? cnt_q + CW'(1) : cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if ((P == '0) || (Q == '0)) begin
            r_d      = P | Q;
            cycles_d = '0;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            x_d     = P;
            y_d     = Q;
            k_d     = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = StStrip;
          end
        end
      end
      StStrip: begin
        // Common factors of two are removed here and restored via k at the end.
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = StOddx;
        end
      end
      StOddx: begin
        if (!x_q[0]) x_d = x_q >> 1;
        else         state_d = StLoop;
      end
      StLoop: begin
        // x is odd here, so the difference of two odds is even and y stays the one to shift.
        if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (y_q == x_q) begin
          r_d      = x_q << k_q;
          cycles_d = cnt_q + CW'(1);
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (x_q > y_q) begin
          x_d = y_q;
          y_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
    end
  end

  assign R      = r_q;
  assign done   = done_q;
  assign busy   = busy_st;
  assign cycles = cycles_q;

endmodule
